// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM state encoding and the operand magnitude helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Widest operand the magnitude helper can handle.
    localparam int ABS_MAX_W = 64;

    // Magnitude of a width-bit operand held zero-extended in a 64-bit word.
    // In signed mode a negative operand is negated. -2^(width-1) maps to
    // 2^(width-1), which still fits in width bits when read as unsigned.
    function automatic logic [ABS_MAX_W-1:0] abs_val(
        input logic [ABS_MAX_W-1:0] value,
        input int                   width,
        input logic                 signed_mode
    );
        logic [ABS_MAX_W-1:0] mask;
        logic                 sign_bit;
        mask     = {ABS_MAX_W{1'b1}} >> (ABS_MAX_W - width);
        sign_bit = |(value & (64'd1 << (width - 1)));
        if (signed_mode && sign_bit) begin
            abs_val = (~value + 64'd1) & mask;
        end else begin
            abs_val = value & mask;
        end
    endfunction

endpackage

// File: rtl/seq_mult_addshift.sv
// One shift-add step of the multiplier.
// The upper half of the product gets the multiplicand added when the
// current low multiplier bit is set. The carry is kept as a WIDTH+1-bit sum.
// The whole 2*WIDTH-bit product then shifts right by one.
module seq_mult_addshift #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] prod_next
);

    logic [WIDTH:0] sum;

    // Conditional add into the upper half, then a 1-bit right shift with the carry shifted in.
    always_comb begin
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {sum, prod[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier with a start/busy/done handshake.
// Signed requests are handled as sign-magnitude: the operand magnitudes are
// multiplied and the product is negated in FIX when the signs differed.
// Optional feature: define MULT_EARLY_TERM_EN to finish CALC as soon as the
// remaining multiplier bits are all zero. Without it, CALC always takes WIDTH cycles.
// Results are the same either way; only the latency changes.
// WIDTH must be between 4 and 64 (the limit comes from the magnitude helper).
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [2*WIDTH-1:0] prod, prod_next;
    logic [2*WIDTH-1:0] step_prod;
    logic [CNT_W-1:0]   counter, counter_next;
    logic               neg, neg_next;
    logic [2*WIDTH-1:0] result_q, result_next;
    logic               done_q, done_next;

    logic [ABS_MAX_W-1:0] a_abs_full, b_abs_full;
    logic [WIDTH-1:0]     a_abs, b_abs;

    assign a_abs_full = abs_val(ABS_MAX_W'(multiplicand), WIDTH, signed_mode);
    assign b_abs_full = abs_val(ABS_MAX_W'(multiplier), WIDTH, signed_mode);
    assign a_abs      = a_abs_full[WIDTH-1:0];
    assign b_abs      = b_abs_full[WIDTH-1:0];

    // Upper bits of the magnitudes are always zero; this keeps them accounted for.
    if (WIDTH < ABS_MAX_W) begin : g_abs_hi
        logic unused_abs_hi;
        assign unused_abs_hi = ^{a_abs_full[ABS_MAX_W-1:WIDTH], b_abs_full[ABS_MAX_W-1:WIDTH]};
    end

`ifdef MULT_EARLY_TERM_EN
    // The mask selects the unprocessed multiplier bits prod[WIDTH-1-counter:0].
    // The shift amount is the number of steps still outstanding.
    logic [WIDTH-1:0] remain_mask;
    logic [CNT_W-1:0] shift_amt;
    assign remain_mask = {WIDTH{1'b1}} >> counter;
    assign shift_amt   = CNT_W'(WIDTH) - counter;
`endif

    seq_mult_addshift #(.WIDTH(WIDTH)) u_addshift (
        .prod      (prod),
        .mcand     (a_reg),
        .prod_next (step_prod)
    );

    assign busy   = (state == ST_CALC) || (state == ST_FIX);
    assign done   = done_q;
    assign result = result_q;

    // Next-state and datapath updates for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        state_next   = state;
        a_next       = a_reg;
        prod_next    = prod;
        counter_next = counter;
        neg_next     = neg;
        result_next  = result_q;
        done_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_next       = a_abs;
                    prod_next    = {{WIDTH{1'b0}}, b_abs};
                    counter_next = '0;
                    neg_next     = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    state_next   = ST_CALC;
                end
            end
            ST_CALC: begin
`ifdef MULT_EARLY_TERM_EN
                if ((prod[WIDTH-1:0] & remain_mask) == '0) begin
                    prod_next  = prod >> shift_amt;
                    state_next = ST_FIX;
                end else
`endif
                begin
                    prod_next    = step_prod;
                    counter_next = counter + CNT_W'(1);
                    if (counter == CNT_W'(WIDTH - 1)) begin
                        state_next = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                result_next = neg ? (~prod + 1'b1) : prod;
                done_next   = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            prod     <= '0;
            counter  <= '0;
            neg      <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            a_reg    <= a_next;
            prod     <= prod_next;
            counter  <= counter_next;
            neg      <= neg_next;
            result_q <= result_next;
            done_q   <= done_next;
        end
    end

endmodule
